// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 32-bit shifter between two requesters,
// with a one-entry result buffer and a saturating completed-op counter.
module shift_arbiter #(
   parameter int CNT_W    = 16,
   parameter int RST_PRIO = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_a,
   input  logic [4:0]       req0_b,
   input  logic [1:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_a,
   input  logic [4:0]       req1_b,
   input  logic [1:0]       req1_op,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_c,
   output logic             res_id,
   output logic             res_err,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t r_state;
   state_t w_nstate;

   logic        r_ptr;
   logic [31:0] r_c;
   logic        r_id;
   logic        r_err;
   logic [CNT_W-1:0] r_cnt;

   logic        w_accept_ok;
   logic        w_gnt;
   logic        w_xfer;
   logic        w_drain;
   logic [31:0] w_a;
   logic [4:0]  w_b;
   logic [1:0]  w_op;
   logic [31:0] w_c;
   logic        w_err;

   assign res_valid = (r_state == S_FULL);
   assign res_c     = r_c;
   assign res_id    = r_id;
   assign res_err   = r_err;
   assign op_count  = r_cnt;

   assign w_accept_ok = !res_valid || res_ready;
   assign w_drain     = res_valid && res_ready;

   // Pointer only breaks ties; a lone requester always wins.
   assign w_gnt = (req0_valid && req1_valid) ? r_ptr
                                             : req1_valid;

   assign req0_ready = rst_n && w_accept_ok
                       && !w_gnt && req0_valid;
   assign req1_ready = rst_n && w_accept_ok
                       && w_gnt && req1_valid;
   assign w_xfer     = req0_ready || req1_ready;

   assign w_a  = w_gnt ? req1_a  : req0_a;
   assign w_b  = w_gnt ? req1_b  : req0_b;
   assign w_op = w_gnt ? req1_op : req0_op;

   always_comb begin
      w_c   = w_a;
      w_err = 1'b0;
      case (w_op)
         2'b00:   w_c = w_a << w_b;
         2'b01:   w_c = w_a >> w_b;
         2'b10:   w_c = $signed(w_a) >>> w_b;
         default: w_err = 1'b1;
      endcase
   end

   always_comb begin
      w_nstate = r_state;
      case (r_state)
         S_EMPTY: begin
            if (w_xfer) w_nstate = S_FULL;
         end
         S_FULL: begin
            if (w_xfer)       w_nstate = S_FULL;
            else if (w_drain) w_nstate = S_EMPTY;
         end
         default: w_nstate = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
         r_ptr   <= 1'(RST_PRIO);
         r_c     <= '0;
         r_id    <= 1'b0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nstate;
         if (w_xfer) begin
            r_c   <= w_c;
            r_id  <= w_gnt;
            r_err <= w_err;
            r_ptr <= ~w_gnt;
         end
         if (w_drain && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit shift datapath (SLL / SRL / SRA, 5-bit shift amount) between two requesters in the ALU IP.
- Round-robin arbitration at the input.
- One-entry registered result buffer at the output, with valid/ready handshakes on every interface.
- Sustains one operation per cycle when the consumer does not stall.
- Keeps a saturating count of completed operations for debug.

Parameters:
- CNT_W, 16, width of the completed-operation counter op_count.
- RST_PRIO, 0, requester favoured on the first contended arbitration after reset (0 or 1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req0_valid  input  1  requester 0 presents an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  32  requester 0 operand.
- req0_b  input  5  requester 0 shift amount.
- req0_op  input  2  requester 0 operation: 00 SLL, 01 SRL, 10 SRA, 11 illegal.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- res_valid  output  1  result buffer holds a result.
- res_ready  input  1  consumer accepts the result.
- res_c  output  32  shift result.
- res_id  output  1  index of the requester that issued the result.
- res_err  output  1  result came from an illegal op (11).
- op_count  output  CNT_W  number of results consumed, saturating.

Behaviour:
- Reset (rst_n low at a clock edge):
  - res_valid=0, res_c=0, res_id=0, res_err=0, op_count=0.
  - Priority pointer set so RST_PRIO wins the next contention.
  - reqX_ready is combinational and low while rst_n is low.
  - A reset mid-operation discards any buffered result; no result is produced for it.
- accept_ok = !res_valid || res_ready. This lets the buffer refill in the same cycle it drains.
- Grant, combinational:
  - Only req0 valid: grant 0.
  - Only req1 valid: grant 1.
  - Both valid: grant the requester the pointer favours.
  - reqX_ready = accept_ok && (grant == X) && reqX_valid. At most one ready is high per cycle.
- Pointer update: only on an accepted transfer. After a grant to X, the pointer favours the other requester. An unaccepted cycle does not move the pointer, so a stalled grant holds its priority.
- Datapath:
  - Shift is computed combinationally from the granted operands and captured in the result buffer on acceptance.
  - SLL: a << b, zero fill.
  - SRL: a >> b, zero fill.
  - SRA: a >>> b, fill with a[31].
  - Op 11: res_c = a, res_err = 1. Otherwise res_err = 0.
  - b = 0 returns a unchanged for every op.
- Latency: transfer accepted at edge N; res_valid=1 with the result from edge N through the cycle after N.
- Result buffer:
  - res_c, res_id and res_err stay stable while res_valid && !res_ready.
  - Drain without refill (res_valid && res_ready, no accepted transfer): res_valid -> 0 next cycle.
  - Drain with refill in the same cycle: res_valid stays 1 and the new result appears next cycle.
- Buffer state, 2 states:
  - EMPTY -> FULL on acceptance.
  - FULL -> FULL on drain plus refill.
  - FULL -> EMPTY on drain without refill.
  - FULL holds while stalled.
- op_count: +1 on each res_valid && res_ready. Holds at 2^CNT_W-1 and does not wrap.
- Requester side: reqX_a/b/op need only be stable in the cycle reqX_valid && reqX_ready. Dropping valid before acceptance is allowed and has no effect.

Test Plan:
- After reset, req0 valid alone with a=0x80000000, b=4, op=10, res_ready=1:
  - req0_ready high in cycle 0.
  - Next cycle: res_valid=1, res_c=0xF8000000, res_id=0, res_err=0.
  - Repeat with op=01 -> res_c=0x08000000.
  - Repeat with a=0x00000001, b=5, op=00 -> res_c=0x00000020.
- Both requesters valid continuously, RST_PRIO=0, res_ready=1:
  - Grants alternate 0,1,0,1.
  - res_id sequence 0,1,0,1 with one result per cycle.
  - op_count=4 after four consumed results.
- Backpressure:
  - Result held with res_ready=0 for 3 cycles while req1 stays valid: req1_ready stays low, and res_c/res_id/res_err stay stable.
  - res_ready rises: req1_ready goes high in that same cycle and the new result appears the next cycle.
- Illegal op: a=0x12345678, b=3, op=11 -> res_c=0x12345678, res_err=1. Edge case b=0 with op=10 -> res_c=a.
- Reset mid-operation:
  - rst_n low while res_valid=1: next cycle res_valid=0 and op_count=0.
  - After release, contention is won by RST_PRIO.
- Counter saturation: CNT_W=2, six consumed results -> op_count=3.
